// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one operand bit per clock, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s, c;
  // state, operand, working and result registers; reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end
  // full-adder step on the LSBs, shift datapath, publish result on the last bit
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    s       = a_q[0] ^ b_q[0] ^ carry_q;
    c       = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    case (state_q)
      IDLE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        carry_d = cin;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        work_d  = WIDTH'({s, work_q} >> 1);
        carry_d = c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = work_d;
          cout_d  = c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus corner-case sequences for serial_adder
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       ci = 1'b0;
  logic       busy8, done8, cout8, busy1, done1, cout1;
  logic [7:0] sum8;
  logic [0:0] sum1;
  int         n_vec = 0, n_err = 0;
  logic [7:0] last8 = '0;
  logic       lastc8 = 1'b0;
  logic       last1 = 1'b0, lastc1 = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t v8[8];
  vec_t v1[8];
  logic [16:0] ops[32];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a), .b_in(b), .cin(ci),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a[0:0]), .b_in(b[0:0]), .cin(ci),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic get(input bit w1, output logic dn, output logic bs, output logic [7:0] sm, output logic co);
    dn = w1 ? done1 : done8;
    bs = w1 ? busy1 : busy8;
    sm = w1 ? {7'b0, sum1} : sum8;
    co = w1 ? cout1 : cout8;
  endtask

  task automatic run_op(input bit w1, input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                        input logic [7:0] es, input logic ec);
    int         cyc;
    bit         hold_ok;
    logic       dn, bs, co;
    logic [7:0] sm, prev_s;
    logic       prev_c;
    int         w;
    w      = w1 ? 1 : 8;
    prev_s = w1 ? {7'b0, last1} : last8;
    prev_c = w1 ? lastc1 : lastc8;
    @(negedge clk);
    a = oa; b = ob; ci = oc;
    if (w1) start1 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    a = ~oa; b = ob ^ 8'h5a; ci = ~oc;
    cyc = 1;
    hold_ok = 1'b1;
    get(w1, dn, bs, sm, co);
    while (!dn && cyc < 40) begin
      if (!bs || sm !== prev_s || co !== prev_c) hold_ok = 1'b0;
      @(negedge clk);
      if (cyc == 2) begin a = $urandom; b = $urandom; ci = $urandom; end
      cyc++;
      get(w1, dn, bs, sm, co);
    end
    check("latency", cyc, w + 1);
    check("busy_at_done", {31'b0, bs}, 1);
    check("sum", {24'b0, sm}, {24'b0, es});
    check("cout", {31'b0, co}, {31'b0, ec});
    check("hold_during_run", {31'b0, hold_ok}, 1);
    if (w1) begin last1 = es[0]; lastc1 = ec; end
    else begin last8 = es; lastc8 = ec; end
    @(negedge clk);
    get(w1, dn, bs, sm, co);
    check("done_single_pulse", {31'b0, dn}, 0);
    check("idle_after_done", {31'b0, bs}, 0);
  endtask

  initial begin
    logic [8:0] t;
    logic [1:0] e1[8];
    bit         no_done;
    logic [7:0] ra, rb;
    logic       rc;
    v8[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    v8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    v8[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    v8[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    v8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    v8[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    v8[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v8[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    e1 = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      v1[i] = '{{7'b0, iv[2]}, {7'b0, iv[1]}, iv[0], {7'b0, e1[i][1]}, e1[i][0]};
    end

    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy8}, 0);
    check("reset_done", {31'b0, done8}, 0);
    check("reset_sum", {24'b0, sum8}, 0);
    check("reset_cout", {31'b0, cout8}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(1'b1, v1[i].a, v1[i].b, v1[i].c, v1[i].s, v1[i].co);
    for (int i = 0; i < 8; i++) run_op(1'b0, v8[i].a, v8[i].b, v8[i].c, v8[i].s, v8[i].co);

    // reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    a = 8'hC3; b = 8'h1E; ci = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy8}, 0);
    check("abort_done", {31'b0, done8}, 0);
    check("abort_sum", {24'b0, sum8}, 0);
    check("abort_cout", {31'b0, cout8}, 0);
    last8 = '0; lastc8 = 1'b0; last1 = 1'b0; lastc1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) no_done = 1'b0;
    end
    check("abort_no_done", {31'b0, no_done}, 1);
    run_op(1'b0, 8'hC3, 8'h1E, 1'b1, 8'hE2, 1'b0);

    // start held high with operands changing every cycle
    for (int k = 0; k < 32; k++) begin
      bit exp_d;
      @(negedge clk);
      if (k >= 1) begin
        exp_d = (k % 10) == 9;
        check("held_start_done", {31'b0, done8}, {31'b0, exp_d});
        if (exp_d) begin
          t = 9'(ops[k-9][16:9]) + 9'(ops[k-9][8:1]) + 9'(ops[k-9][0]);
          check("held_start_sum", {24'b0, sum8}, {24'b0, t[7:0]});
          check("held_start_cout", {31'b0, cout8}, {31'b0, t[8]});
        end
      end
      a = $urandom; b = $urandom; ci = $urandom;
      start8 = 1'b1;
      ops[k] = {a, b, ci};
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    t = 9'(ops[30][16:9]) + 9'(ops[30][8:1]) + 9'(ops[30][0]);
    check("held_start_last_sum", {24'b0, sum8}, {24'b0, t[7:0]});
    last8 = t[7:0]; lastc8 = t[8];

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      t = 9'(ra) + 9'(rb) + 9'(rc);
      run_op(1'b0, ra, rb, rc, t[7:0], t[8]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add; sampled on the rising clk edge.
REQ-005 a_in  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b_in  input  WIDTH  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (RUN or DONE state).
REQ-009 done  output  1  one-cycle pulse marking a new valid result.
REQ-010 sum  output  WIDTH  result register; (a + b + cin) mod 2^WIDTH.
REQ-011 cout  output  1  result carry-out; bit WIDTH of a + b + cin.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE, with a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-013 IDLE with start=1 at an edge: load A and B shift registers from a_in and b_in, load the carry flop from cin, clear the counter, and go to RUN.
REQ-014 IDLE with start=0: hold all state.
REQ-015 RUN, each edge: s = A[0] xor B[0] xor carry; c = majority(A[0], B[0], carry). Shift A and B right by one, shift s into the MSB of the working sum register, carry <= c, counter += 1.
REQ-016 The RUN-to-DONE transition SHALL occur on the edge that processes bit WIDTH-1, so there are exactly WIDTH RUN cycles.
REQ-017 On the same edge, sum SHALL be loaded from the completed working register, cout from c, and done SHALL be set.
REQ-018 DONE SHALL last exactly one cycle (done=1, busy=1) and return unconditionally to IDLE.
REQ-019 Latency: start accepted at edge T results in done high during the cycle after edge T+WIDTH. There are WIDTH+1 cycles from acceptance to the done pulse, and the next start can be accepted at edge T+WIDTH+2.
REQ-020 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 start asserted in RUN or DONE SHALL be ignored and not queued; the in-flight operands and result are unaffected.
REQ-022 Changes to a_in, b_in or cin after acceptance SHALL have no effect on the in-flight operation.
REQ-023 sum and cout SHALL hold their last result from done until the next DONE entry; they SHALL NOT show partial values during RUN.
REQ-024 For WIDTH=1, the block SHALL reduce to one registered full-adder evaluation per operation, matching the full-adder truth table.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, and A/B/working registers=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the result outputs read 0.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, a=0x00, b=0x00, cin=0, start one cycle -> busy for 9 cycles, done pulse on the 9th cycle after acceptance, sum=0x00, cout=0.
REQ-029 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
REQ-030 WIDTH=1, all 8 combinations of a, b, cin in order 000..111 -> (sum,cout) = 00,10,10,01,10,01,01,11, each with a single done pulse.
REQ-031 Start held high continuously with operands changed every cycle -> only the operands at each IDLE acceptance are used; done pulses are spaced WIDTH+2 cycles apart.
REQ-032 Start accepted, rst_n pulsed low at RUN cycle 4 -> no done pulse, busy=0 and sum=0 immediately; a following start computes correctly.
REQ-033 Randomised WIDTH=8 (>=1000 operations) checked against a+b+cin -> zero mismatches, and exactly one done pulse per accepted start.
